// File: rtl/rv_pipe_pkg.sv
// Shared helpers for the valid/ready pipeline blocks: pointer width and max.
package rv_pipe_pkg;

  // Pointer width for a ring of n entries; never narrower than one bit.
  function automatic int RV_CLOG2(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

  function automatic int RV_MAX(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rv_elastic_buffer_if.sv
// Valid/ready bundle between an upstream producer, the elastic buffer and a downstream consumer.
interface rv_elastic_buffer_if #(
  parameter int DATAW = 8
);
  // Handshake: a beat moves on a rising edge where its valid and ready are both 1.
  // The buffer makes no assumption that valid_in/data_in hold while ready_in=0;
  // it guarantees valid_out/data_out hold while valid_out=1 and ready_out=0.
  logic             valid_in;
  logic [DATAW-1:0] data_in;
  logic             ready_in;
  logic             valid_out;
  logic [DATAW-1:0] data_out;
  logic             ready_out;

  modport slave (
    input  valid_in, data_in, ready_out,
    output ready_in, valid_out, data_out
  );

  modport master (
    output valid_in, data_in, ready_out,
    input  ready_in, valid_out, data_out
  );
endinterface

// File: rtl/rv_fifo_ctrl.sv
// Occupancy and ring pointers for the multi-entry elastic buffer.
module rv_fifo_ctrl
  import rv_pipe_pkg::*;
#(
  parameter int SIZE = 2,
  localparam int PTRW = RV_CLOG2(SIZE),
  localparam int CNTW = $clog2(SIZE + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  output logic [PTRW-1:0] rd_ptr,
  output logic [PTRW-1:0] wr_ptr,
  output logic            full,
  output logic            empty
);

  logic [CNTW-1:0] count;

  assign full  = (count == CNTW'(SIZE));
  assign empty = (count == '0);

  // Explicit wrap keeps non-power-of-two depths legal.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
      if (push) wr_ptr <= (wr_ptr == PTRW'(SIZE - 1)) ? '0 : wr_ptr + PTRW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTRW'(SIZE - 1)) ? '0 : rd_ptr + PTRW'(1);
    end
  end

endmodule

// File: rtl/rv_elastic_buffer.sv
// Valid/ready elastic stage: SIZE=1 is a pass-through-ready register, SIZE>=2 a registered-ready ring.
module rv_elastic_buffer
  import rv_pipe_pkg::*;
#(
  parameter int DATAW = 8,
  parameter int SIZE  = 2
) (
  input logic                clk,
  input logic                reset,
  rv_elastic_buffer_if.slave bus
);

  localparam int DEPTH = RV_MAX(SIZE, 1);
  localparam int PTRW  = RV_CLOG2(DEPTH);

  generate
    if (SIZE == 1) begin : g_single
      logic             valid_q;
      logic [DATAW-1:0] data_q;
      logic             ready;
      logic             push;

      // The one combinational ready path: a pop frees the register this same cycle.
      assign ready = ~valid_q | bus.ready_out;
      assign push  = bus.valid_in & ready;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset)             valid_q <= 1'b0;
        else if (push)          valid_q <= 1'b1;
        else if (bus.ready_out) valid_q <= 1'b0;
      end

      always_ff @(posedge clk) begin
        if (push) data_q <= bus.data_in;
      end

      assign bus.ready_in  = ready;
      assign bus.valid_out = valid_q;
      assign bus.data_out  = data_q;
    end else begin : g_ring
      logic [DATAW-1:0] mem [DEPTH];
      logic [PTRW-1:0]  rd_ptr;
      logic [PTRW-1:0]  wr_ptr;
      logic             full;
      logic             empty;
      logic             push;
      logic             pop;

      // Full blocks a push even when a pop frees a slot in the same cycle.
      assign push = bus.valid_in & ~full;
      assign pop  = ~empty & bus.ready_out;

      rv_fifo_ctrl #(.SIZE(SIZE)) u_ctrl (
        .clk    (clk),
        .reset  (reset),
        .push   (push),
        .pop    (pop),
        .rd_ptr (rd_ptr),
        .wr_ptr (wr_ptr),
        .full   (full),
        .empty  (empty)
      );

      always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.data_in;
      end

      assign bus.ready_in  = ~full;
      assign bus.valid_out = ~empty;
      assign bus.data_out  = mem[rd_ptr];
    end
  endgenerate

endmodule

// File: tb/tb_rv_elastic_buffer.sv
// Directed bench for rv_elastic_buffer at SIZE=1, 2 and 3, plus a random order scoreboard at SIZE=3.
module tb_rv_elastic_buffer;

  logic clk;
  logic rst_n;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_fail = 0;
  logic [7:0] exp_q[$];

  rv_elastic_buffer_if #(.DATAW(8)) b1 ();
  rv_elastic_buffer_if #(.DATAW(8)) b2 ();
  rv_elastic_buffer_if #(.DATAW(8)) b3 ();

  rv_elastic_buffer #(.DATAW(8), .SIZE(1)) dut1 (.clk(clk), .reset(rst_n), .bus(b1.slave));
  rv_elastic_buffer #(.DATAW(8), .SIZE(2)) dut2 (.clk(clk), .reset(rst_n), .bus(b2.slave));
  rv_elastic_buffer #(.DATAW(8), .SIZE(3)) dut3 (.clk(clk), .reset(rst_n), .bus(b3.slave));

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    b1.valid_in = 0; b1.data_in = '0; b1.ready_out = 0;
    b2.valid_in = 0; b2.data_in = '0; b2.ready_out = 0;
    b3.valid_in = 0; b3.data_in = '0; b3.ready_out = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) step();
    n_chk++; if (b2.valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_s2_valid got %b exp 0", b2.valid_out); end else n_pass++;
    n_chk++; if (b2.ready_in !== 1'b1) begin n_fail++; $display("FAIL reset_s2_ready got %b exp 1", b2.ready_in); end else n_pass++;
    n_chk++; if (b3.valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_s3_valid got %b exp 0", b3.valid_out); end else n_pass++;
    n_chk++; if (b1.valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_s1_valid got %b exp 0", b1.valid_out); end else n_pass++;
    rst_n = 1;
    step();
    n_chk++; if (b2.ready_in !== 1'b1) begin n_fail++; $display("FAIL idle_s2_ready got %b exp 1", b2.ready_in); end else n_pass++;
    n_chk++; if (b2.valid_out !== 1'b0) begin n_fail++; $display("FAIL idle_s2_valid got %b exp 0", b2.valid_out); end else n_pass++;
    // Fill with two beats, then reset asynchronously mid-cycle
    b2.ready_out = 0;
    b2.valid_in = 1; b2.data_in = 8'hE1; step();
    b2.data_in = 8'hE2; step();
    b2.valid_in = 0;
    n_chk++; if (b2.ready_in !== 1'b0) begin n_fail++; $display("FAIL prefill_ready got %b exp 0", b2.ready_in); end else n_pass++;
    n_chk++; if (b2.data_out !== 8'hE1) begin n_fail++; $display("FAIL prefill_head got %h exp e1", b2.data_out); end else n_pass++;
    #2 rst_n = 0;
    #1;
    n_chk++; if (b2.valid_out !== 1'b0) begin n_fail++; $display("FAIL async_reset_valid got %b exp 0", b2.valid_out); end else n_pass++;
    n_chk++; if (b2.ready_in !== 1'b1) begin n_fail++; $display("FAIL async_reset_ready got %b exp 1", b2.ready_in); end else n_pass++;
    step();
    rst_n = 1;
    b2.ready_out = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_chk++; if (b2.valid_out !== 1'b0) begin n_fail++; $display("FAIL dropped_beats_valid cyc %0d got %b exp 0", i, b2.valid_out); end else n_pass++;
    end
    b2.ready_out = 0;
  endtask

  task automatic test_streaming();
    b2.ready_out = 1;
    for (int i = 1; i <= 16; i++) begin
      b2.valid_in = 1; b2.data_in = 8'(i);
      step();
      n_chk++; if (b2.valid_out !== 1'b1 || b2.data_out !== 8'(i)) begin
        n_fail++; $display("FAIL stream_beat %0d got v=%b d=%h exp v=1 d=%h", i, b2.valid_out, b2.data_out, 8'(i));
      end else n_pass++;
      n_chk++; if (b2.ready_in !== 1'b1) begin n_fail++; $display("FAIL stream_ready %0d got %b exp 1", i, b2.ready_in); end else n_pass++;
    end
    b2.valid_in = 0;
    step();
    n_chk++; if (b2.valid_out !== 1'b0) begin n_fail++; $display("FAIL stream_drained got %b exp 0", b2.valid_out); end else n_pass++;
    b2.ready_out = 0;
  endtask

  task automatic test_back_pressure();
    b2.ready_out = 0;
    b2.valid_in = 1; b2.data_in = 8'hA1; step();
    n_chk++; if (b2.ready_in !== 1'b1) begin n_fail++; $display("FAIL bp_ready_one got %b exp 1", b2.ready_in); end else n_pass++;
    b2.data_in = 8'hA2; step();
    n_chk++; if (b2.ready_in !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full got %b exp 0", b2.ready_in); end else n_pass++;
    b2.data_in = 8'hBB;
    for (int i = 0; i < 5; i++) begin
      step();
      n_chk++; if (b2.valid_out !== 1'b1 || b2.data_out !== 8'hA1) begin
        n_fail++; $display("FAIL bp_stall %0d got v=%b d=%h exp v=1 d=a1", i, b2.valid_out, b2.data_out);
      end else n_pass++;
    end
    b2.valid_in = 0;
    b2.ready_out = 1;
    #1;
    n_chk++; if (b2.ready_in !== 1'b0) begin n_fail++; $display("FAIL bp_no_comb_ready got %b exp 0", b2.ready_in); end else n_pass++;
    step();
    n_chk++; if (b2.data_out !== 8'hA2 || b2.valid_out !== 1'b1) begin
      n_fail++; $display("FAIL bp_second got v=%b d=%h exp v=1 d=a2", b2.valid_out, b2.data_out);
    end else n_pass++;
    n_chk++; if (b2.ready_in !== 1'b1) begin n_fail++; $display("FAIL bp_ready_back got %b exp 1", b2.ready_in); end else n_pass++;
    step();
    n_chk++; if (b2.valid_out !== 1'b0) begin n_fail++; $display("FAIL bp_empty got %b exp 0", b2.valid_out); end else n_pass++;
    b2.ready_out = 0;
  endtask

  task automatic test_full_pop();
    logic [7:0] drain [3];
    drain[0] = 8'h32; drain[1] = 8'h3F; drain[2] = 8'h33;
    b3.ready_out = 0;
    b3.valid_in = 1; b3.data_in = 8'h31; step();
    b3.data_in = 8'h32; step();
    b3.data_in = 8'h3F; step();
    n_chk++; if (b3.ready_in !== 1'b0) begin n_fail++; $display("FAIL fp_full_ready got %b exp 0", b3.ready_in); end else n_pass++;
    b3.data_in = 8'h33; b3.ready_out = 1;
    #1;
    n_chk++; if (b3.ready_in !== 1'b0 || b3.data_out !== 8'h31) begin
      n_fail++; $display("FAIL fp_pop_cycle got r=%b d=%h exp r=0 d=31", b3.ready_in, b3.data_out);
    end else n_pass++;
    step();
    n_chk++; if (b3.ready_in !== 1'b1 || b3.data_out !== 8'h32) begin
      n_fail++; $display("FAIL fp_after_pop got r=%b d=%h exp r=1 d=32", b3.ready_in, b3.data_out);
    end else n_pass++;
    b3.ready_out = 0;
    step();
    n_chk++; if (b3.ready_in !== 1'b0 || b3.data_out !== 8'h32) begin
      n_fail++; $display("FAIL fp_late_push got r=%b d=%h exp r=0 d=32", b3.ready_in, b3.data_out);
    end else n_pass++;
    b3.valid_in = 0; b3.ready_out = 1;
    for (int k = 0; k < 3; k++) begin
      n_chk++; if (b3.valid_out !== 1'b1 || b3.data_out !== drain[k]) begin
        n_fail++; $display("FAIL fp_drain %0d got v=%b d=%h exp v=1 d=%h", k, b3.valid_out, b3.data_out, drain[k]);
      end else n_pass++;
      step();
    end
    n_chk++; if (b3.valid_out !== 1'b0) begin n_fail++; $display("FAIL fp_drained got %b exp 0", b3.valid_out); end else n_pass++;
    b3.ready_out = 0;
  endtask

  task automatic test_wrap_random();
    int wrap_err = 0;
    int pushes = 0;
    bit push, pop;
    exp_q.delete();
    for (int c = 0; c < 1000; c++) begin
      b3.valid_in  = ($urandom_range(0, 99) < 60);
      b3.data_in   = 8'($urandom_range(0, 255));
      b3.ready_out = ($urandom_range(0, 99) < 50);
      #1;
      if (b3.ready_in !== (exp_q.size() != 3) || b3.valid_out !== (exp_q.size() != 0) ||
          (exp_q.size() != 0 && b3.data_out !== exp_q[0])) begin
        wrap_err++;
        if (wrap_err <= 5)
          $display("FAIL wrap_cycle %0d got r=%b v=%b d=%h exp count=%0d head=%h", c, b3.ready_in,
                   b3.valid_out, b3.data_out, exp_q.size(), (exp_q.size() != 0) ? exp_q[0] : 8'h00);
      end
      push = b3.valid_in && (exp_q.size() != 3);
      pop  = b3.ready_out && (exp_q.size() != 0);
      if (pop) void'(exp_q.pop_front());
      if (push) begin exp_q.push_back(b3.data_in); pushes++; end
      step();
    end
    n_chk++; if (wrap_err != 0) begin n_fail++; $display("FAIL wrap_total errors=%0d exp 0", wrap_err); end else n_pass++;
    n_chk++; if (pushes < 100) begin n_fail++; $display("FAIL wrap_activity pushes=%0d exp >=100", pushes); end else n_pass++;
    b3.valid_in = 0; b3.ready_out = 1;
    while (exp_q.size() != 0) begin
      n_chk++; if (b3.valid_out !== 1'b1 || b3.data_out !== exp_q[0]) begin
        n_fail++; $display("FAIL wrap_drain got v=%b d=%h exp v=1 d=%h", b3.valid_out, b3.data_out, exp_q[0]);
      end else n_pass++;
      void'(exp_q.pop_front());
      step();
    end
    n_chk++; if (b3.valid_out !== 1'b0) begin n_fail++; $display("FAIL wrap_empty got %b exp 0", b3.valid_out); end else n_pass++;
    b3.ready_out = 0;
  endtask

  task automatic test_single_passthrough();
    b1.ready_out = 0;
    b1.valid_in = 1; b1.data_in = 8'h55; step();
    n_chk++; if (b1.valid_out !== 1'b1 || b1.data_out !== 8'h55) begin
      n_fail++; $display("FAIL s1_load got v=%b d=%h exp v=1 d=55", b1.valid_out, b1.data_out);
    end else n_pass++;
    b1.data_in = 8'h77;
    #1;
    n_chk++; if (b1.ready_in !== 1'b0) begin n_fail++; $display("FAIL s1_full_ready got %b exp 0", b1.ready_in); end else n_pass++;
    step();
    n_chk++; if (b1.data_out !== 8'h55) begin n_fail++; $display("FAIL s1_hold got %h exp 55", b1.data_out); end else n_pass++;
    b1.data_in = 8'h66; b1.ready_out = 1;
    #1;
    n_chk++; if (b1.ready_in !== 1'b1) begin n_fail++; $display("FAIL s1_comb_ready got %b exp 1", b1.ready_in); end else n_pass++;
    step();
    n_chk++; if (b1.valid_out !== 1'b1 || b1.data_out !== 8'h66) begin
      n_fail++; $display("FAIL s1_replace got v=%b d=%h exp v=1 d=66", b1.valid_out, b1.data_out);
    end else n_pass++;
    b1.valid_in = 0;
    step();
    n_chk++; if (b1.valid_out !== 1'b0) begin n_fail++; $display("FAIL s1_clear got %b exp 0", b1.valid_out); end else n_pass++;
    b1.ready_out = 0;
  endtask

  initial begin
    rst_n = 0;
    idle_all();
    test_reset();
    test_streaming();
    test_back_pressure();
    test_full_pop();
    test_wrap_random();
    test_single_passthrough();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rv_elastic_buffer.md
Name: rv_elastic_buffer

Overview:
Valid/ready elastic pipeline stage. It is the back-pressure counterpart of the team's enable-driven pipe register: the consumer stalls the producer through ready instead of through a shared enable. It sits between two pipeline stages, for example issue→dispatch or writeback arbitration, so that a stall in the downstream stage does not form a combinational path to upstream. It buffers up to SIZE beats and preserves order.

Parameters:
DATAW, 8, payload width in bits (≥1)
SIZE, 2, buffer depth in entries (≥1); 1 = single stage with pass-through ready, 2 = skid buffer, >2 = small FIFO

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
valid_in  input  1  upstream beat valid
data_in  input  DATAW  upstream payload
ready_in  output  1  buffer can accept a beat this cycle
valid_out  output  1  downstream beat valid
data_out  output  DATAW  downstream payload (head entry)
ready_out  input  1  downstream accepts head this cycle

Behaviour:
- Push = valid_in & ready_in. Pop = valid_out & ready_out. Both evaluated at the same rising edge.
- Reset (reset=0, asynchronous):
  - count, rd_ptr and wr_ptr clear to 0; valid_out=0.
  - Storage is not reset; data_out is don't-care until the first push.
  - ready_in=1 once reset deasserts. Handshakes while reset=0 are ignored.
  - Reset mid-operation drops every buffered beat.
- Latency: a beat pushed at edge t appears on valid_out/data_out after edge t, provided the buffer was empty. With no stall, throughput is 1 beat/cycle for every SIZE.
- Ordering: strict FIFO. No beat is duplicated or dropped.
- Stability: while valid_out=1 and ready_out=0, valid_out and data_out hold constant.
- SIZE=1:
  - ready_in = ~valid_out | ready_out. This is the only combinational ready path.
  - Push together with pop on a full register replaces the head in the same cycle.
  - valid_out clears on a pop with no push.
- SIZE≥2:
  - ready_in is registered: ready_in = (count != SIZE). There is no combinational path from ready_out to ready_in.
  - When count==SIZE, no push occurs even if a pop happens that cycle. ready_in rises the cycle after the pop.
  - count' = count + push − pop. Push and pop together leave count unchanged.
  - valid_out = (count != 0), registered.
  - data_out = mem[rd_ptr], combinational read of the registered head.
  - Pointers are $clog2(SIZE)-bit, or 1 bit when SIZE=2. They wrap from SIZE−1 to 0 explicitly, so non-power-of-two SIZE is legal.
  - On push, mem[wr_ptr] is written and wr_ptr advances. On pop, rd_ptr advances.
- Empty: pop is impossible because valid_out=0. A push into an empty buffer makes valid_out=1 next cycle.
- Full (SIZE≥2): ready_in=0. valid_in may stay high and must not corrupt state.
- Upstream and downstream may change valid_in/data_in freely when ready_in=0. The buffer makes no assumption about protocol stability on its input.

Decomposition:
- Shared package rv_pipe_pkg:
  - RV_CLOG2 / pointer-width helper (returns 1 for SIZE≤2)
  - RV_MAX helper
- One natural sub-module, rv_fifo_ctrl (parameter SIZE):
  - owns count, rd_ptr, wr_ptr, full and empty
  - inputs: push, pop
  - used for SIZE≥2
- Storage stays in rv_elastic_buffer as an unreset register array.
- The SIZE=1 branch is a single register plus valid flop, chosen in a generate block.

Test Plan:
1. Reset then idle (SIZE=2) → valid_out=0, ready_in=1. Assert reset=0 mid-transfer with 2 beats held → next cycle valid_out=0, ready_in=1, and the beats never appear.
2. Streaming (SIZE=2, ready_out=1, beats 0x01..0x10 back-to-back) → data_out = 0x01..0x10 in order, one cycle after each push, ready_in constant 1.
3. Back-pressure (SIZE=2):
   - push 0xA1, 0xA2 with ready_out=0 → ready_in=0 after the second push; data_out=0xA1 stable for 5 stall cycles.
   - release ready_out → 0xA1 then 0xA2, and ready_in returns to 1 one cycle after the first pop.
4. Full with simultaneous pop (SIZE=3, count=3, valid_in=1 with 0x33, ready_out=1) → no push that cycle, count=2, ready_in=1 next cycle. 0x33 is accepted the following cycle and emerges after the two older beats.
5. Wrap-around (SIZE=3, random valid_in/ready_out over 1000 cycles) → scoreboard order is exact, count stays ≤3, no ready_in=1 when count=3, pointers cycle through 0,1,2,0.
6. SIZE=1 pass-through (register full with 0x55, ready_out=1, valid_in=1 with 0x66 in the same cycle) → ready_in=1 combinationally, data_out=0x66 next cycle, 0x55 consumed exactly once.
